// File: rtl/stk_pkg.sv
// stk_pkg: shared types and constants for the stack pipeline front end.
//   ENGS_N   number of requesting engines
//   PTRS_N   free-list capacity shared with the allocator
//   engid_t  engine identifier
//   credit_t free-pointer credit count, sized to hold PTRS_N
//   depth_t  per-engine stack depth, same width as credit_t
//   grant_op_e  classification of the command granted in a cycle
package stk_pkg;

  localparam int unsigned ENGS_N   = 4;
  localparam int unsigned PTRS_N   = 256;
  localparam int unsigned ENGID_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
  localparam int unsigned CREDIT_W = $clog2(PTRS_N + 1);

  typedef logic [ENGID_W-1:0]  engid_t;
  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [CREDIT_W-1:0] depth_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP_OK  = 2'd2,
    OP_POP_UNF = 2'd3
  } grant_op_e;

endpackage

// File: rtl/stk_rr_arb.sv
// stk_rr_arb: combinational N-way round-robin picker.
//   i_req  request vector
//   i_ptr  highest-priority index this cycle
//   o_gnt  one-hot grant
//   o_idx  encoded index of the granted requester
//   o_vld  any grant
module stk_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  // Scanning ptr, ptr+1, ... modulo N covers "at or above the pointer"
  // first and the wrap to the lowest index in a single pass.
  always_comb begin
    logic [IW-1:0] w_k;
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_k   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_k = IW'((32'(i_ptr) + i) % N);
      if (!o_vld && i_req[w_k]) begin
        o_vld      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/stk_eng_sched.sv
// stk_eng_sched: per-engine command scheduler ahead of stack admission.
// Round-robin grants one command per cycle, allows one outstanding command
// per engine, and tracks the free-pointer credit pool and per-engine depth.
//   clk, arst          clock, asynchronous active-high reset
//   i_cmd_vld/push     per-engine request and opcode (1 = push, 0 = pop)
//   o_cmd_ack          combinational one-hot grant
//   i_stall            downstream busy, blocks all grants
//   o_al_alloc         pointer allocate pulse (granted push)
//   o_sel_*            registered winner, one cycle after the grant
//   i_cpl_*            writeback completion, optional pointer return
//   o_busy             per-engine outstanding flag
//   o_credit           free pointers available
module stk_eng_sched
  import stk_pkg::*;
#(
  parameter  int unsigned ENGS_N = stk_pkg::ENGS_N,
  parameter  int unsigned PTRS_N = stk_pkg::PTRS_N,
  localparam int unsigned CW     = $clog2(PTRS_N + 1)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [ENGS_N-1:0] i_cmd_vld,
  input  logic [ENGS_N-1:0] i_cmd_push,
  output logic [ENGS_N-1:0] o_cmd_ack,
  input  logic              i_stall,
  output logic              o_al_alloc,
  output logic              o_sel_vld,
  output engid_t            o_sel_engid,
  output logic              o_sel_push,
  output logic              o_sel_underflow,
  input  logic              i_cpl_vld,
  input  engid_t            i_cpl_engid,
  input  logic              i_cpl_dealloc,
  output logic [ENGS_N-1:0] o_busy,
  output logic [CW-1:0]     o_credit
);

  engid_t            r_rr_ptr;
  logic [ENGS_N-1:0] r_busy;
  logic [CW-1:0]     r_credit;
  logic [CW-1:0]     r_depth [ENGS_N];
  logic              r_sel_vld;
  engid_t            r_sel_engid;
  logic              r_sel_push;
  logic              r_sel_unf;

  logic [ENGS_N-1:0] w_elig;
  logic [ENGS_N-1:0] w_gnt;
  logic [ENGS_N-1:0] w_cpl_mask;
  engid_t            w_idx;
  logic              w_any;
  logic              w_push;
  logic              w_alloc;
  logic              w_ret;
  grant_op_e         w_op;

  // Registered busy means a completion only re-enables an engine next cycle.
  assign w_elig = i_cmd_vld & ~r_busy & {ENGS_N{~i_stall}} &
                  (~i_cmd_push | {ENGS_N{r_credit != '0}});

  stk_rr_arb #(
    .N  (ENGS_N),
    .IW ($bits(engid_t))
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_any)
  );

  assign w_push = i_cmd_push[w_idx];

  always_comb begin
    w_op = OP_NONE;
    if (w_any) begin
      if (w_push)                     w_op = OP_PUSH;
      else if (r_depth[w_idx] == '0)  w_op = OP_POP_UNF;
      else                            w_op = OP_POP_OK;
    end
  end

  always_comb begin
    w_cpl_mask = '0;
    if (i_cpl_vld) w_cpl_mask[i_cpl_engid] = 1'b1;
  end

  assign w_alloc = (w_op == OP_PUSH);
  assign w_ret   = i_cpl_vld & i_cpl_dealloc;

  // The arbiter is combinational, so grants are masked while reset is held.
  assign o_cmd_ack  = arst ? '0 : w_gnt;
  assign o_al_alloc = w_alloc & ~arst;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rr_ptr    <= '0;
      r_busy      <= '0;
      r_credit    <= CW'(PTRS_N);
      for (int unsigned e = 0; e < ENGS_N; e++) r_depth[e] <= '0;
      r_sel_vld   <= 1'b0;
      r_sel_engid <= '0;
      r_sel_push  <= 1'b0;
      r_sel_unf   <= 1'b0;
    end else begin
      r_busy    <= (r_busy | w_gnt) & ~w_cpl_mask;
      // Push grant and dealloc in the same cycle cancel out.
      r_credit  <= r_credit - CW'(w_alloc) + CW'(w_ret);
      r_sel_vld <= w_any;
      if (w_any) begin
        r_sel_engid <= w_idx;
        r_sel_push  <= w_push;
        r_sel_unf   <= (w_op == OP_POP_UNF);
        r_rr_ptr    <= (32'(w_idx) == ENGS_N - 1) ? '0 : w_idx + engid_t'(1);
      end
      case (w_op)
        OP_PUSH:   r_depth[w_idx] <= r_depth[w_idx] + CW'(1);
        OP_POP_OK: r_depth[w_idx] <= r_depth[w_idx] - CW'(1);
        default:   ;
      endcase
    end
  end

  assign o_sel_vld       = r_sel_vld;
  assign o_sel_engid     = r_sel_engid;
  assign o_sel_push      = r_sel_push;
  assign o_sel_underflow = r_sel_unf;
  assign o_busy          = r_busy;
  assign o_credit        = r_credit;

`ifndef SYNTHESIS
  a_cpl_busy: assert property (@(posedge clk) disable iff (arst)
    i_cpl_vld |-> r_busy[i_cpl_engid]);
  a_credit_max: assert property (@(posedge clk) disable iff (arst)
    32'(r_credit) <= PTRS_N);
`endif

endmodule

// File: tb/tb_stk_eng_sched.sv
module tb_stk_eng_sched;
  import stk_pkg::*;

  localparam int unsigned N = 4;
  localparam int P = 256;

  logic         clk = 1'b0;
  logic         arst;
  logic [N-1:0] cmd_vld, cmd_push, ack, busy;
  logic         stall, alloc, sel_vld, sel_push, sel_unf;
  engid_t       sel_eng, cpl_eng;
  logic         cpl_vld, cpl_dealloc;
  logic [8:0]   credit;

  always #5 clk = ~clk;

  stk_eng_sched #(.ENGS_N(N), .PTRS_N(P)) dut (
    .clk(clk), .arst(arst), .i_cmd_vld(cmd_vld), .i_cmd_push(cmd_push),
    .o_cmd_ack(ack), .i_stall(stall), .o_al_alloc(alloc),
    .o_sel_vld(sel_vld), .o_sel_engid(sel_eng), .o_sel_push(sel_push),
    .o_sel_underflow(sel_unf), .i_cpl_vld(cpl_vld), .i_cpl_engid(cpl_eng),
    .i_cpl_dealloc(cpl_dealloc), .o_busy(busy), .o_credit(credit)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: abstract scheduler state.
  bit mb[N];
  int mc;
  int md[N];
  int mp;
  bit msv, msp, msu;
  int mse;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mb[i] = 0; md[i] = 0; end
    mc = P; mp = 0; msv = 0; msp = 0; msu = 0; mse = 0;
  endtask

  function automatic logic [N-1:0] mbv();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mb[i];
    return v;
  endfunction

  // Winner: first eligible engine scanning from the pointer, wrapping.
  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int e;
      e = (mp + i) % N;
      if (cmd_vld[e] && !mb[e] && !stall && (!cmd_push[e] || mc != 0)) return e;
    end
    return -1;
  endfunction

  task automatic model_update(input int w);
    if (w >= 0) begin
      mb[w] = 1; mp = (w + 1) % N; msv = 1; mse = w; msp = cmd_push[w];
      if (cmd_push[w]) begin mc--; md[w]++; msu = 0; end
      else if (md[w] > 0) begin md[w]--; msu = 0; end
      else msu = 1;
    end else begin
      msv = 0;
    end
    if (cpl_vld) begin
      mb[cpl_eng] = 0;
      if (cpl_dealloc) mc++;
    end
  endtask

  // One clock: sample combinational grant mid-cycle, advance model at the edge.
  task automatic tick(output logic [N-1:0] ao, output logic [N-1:0] ae,
                      output logic lo, output logic le);
    int w;
    @(negedge clk);
    ao = ack; lo = alloc;
    w  = pick();
    ae = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    le = (w >= 0) && cmd_push[w];
    @(posedge clk);
    model_update(w);
    #1;
  endtask

  task automatic drain(input bit dealloc);
    logic [N-1:0] ao, ae;
    logic lo, le;
    cmd_vld = '0; stall = 0;
    for (int e = 0; e < N; e++) begin
      if (mb[e]) begin
        cpl_vld = 1; cpl_eng = engid_t'(e); cpl_dealloc = dealloc && (mc < P);
        tick(ao, ae, lo, le);
      end
    end
    cpl_vld = 0; cpl_dealloc = 0;
  endtask

  task automatic test_reset();
    arst = 1; cmd_vld = '1; cmd_push = '1; stall = 0;
    cpl_vld = 0; cpl_eng = '0; cpl_dealloc = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got %b exp 0000", ack); end
    n_chk++; if (busy !== 4'b0000) begin n_err++; $display("FAIL reset_busy got %b exp 0000", busy); end
    n_chk++; if (credit !== 9'd256) begin n_err++; $display("FAIL reset_credit got %0d exp 256", credit); end
    n_chk++; if ({sel_vld, sel_eng, sel_push, sel_unf} !== 5'b0) begin
      n_err++; $display("FAIL reset_sel got %b exp 00000", {sel_vld, sel_eng, sel_push, sel_unf});
    end
    cmd_vld = '0; cmd_push = '0;
    @(negedge clk); arst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_all_push();
    logic [N-1:0] ao, ae;
    logic lo, le;
    cmd_vld = '1; cmd_push = '1;
    for (int i = 0; i < 5; i++) begin
      tick(ao, ae, lo, le);
      n_chk++; if (ao !== ae) begin n_err++; $display("FAIL allpush_ack%0d got %b exp %b", i, ao, ae); end
      n_chk++; if (lo !== le) begin n_err++; $display("FAIL allpush_alloc%0d got %b exp %b", i, lo, le); end
      n_chk++; if (sel_vld !== msv || sel_eng !== 2'(mse)) begin
        n_err++; $display("FAIL allpush_sel%0d got v%b e%0d exp v%b e%0d", i, sel_vld, sel_eng, msv, mse);
      end
    end
    n_chk++; if (credit !== 9'd252) begin n_err++; $display("FAIL allpush_credit got %0d exp 252", credit); end
    n_chk++; if (busy !== 4'b1111) begin n_err++; $display("FAIL allpush_busy got %b exp 1111", busy); end
    drain(1);
  endtask

  task automatic test_underflow();
    logic [N-1:0] ao, ae;
    logic lo, le;
    cmd_vld = 4'b0010; cmd_push = 4'b0000;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== ae) begin n_err++; $display("FAIL pop1_ack got %b exp %b", ao, ae); end
    n_chk++; if (sel_unf !== 1'b0) begin n_err++; $display("FAIL pop1_unf got %b exp 0", sel_unf); end
    drain(0);
    for (int r = 0; r < 2; r++) begin
      cmd_vld = 4'b0010; cmd_push = 4'b0000;
      tick(ao, ae, lo, le);
      n_chk++; if (ao !== 4'b0010 || ao !== ae) begin n_err++; $display("FAIL unf_ack%0d got %b exp %b", r, ao, ae); end
      n_chk++; if (sel_vld !== 1'b1 || sel_unf !== 1'b1 || sel_eng !== 2'd1) begin
        n_err++; $display("FAIL unf_sel%0d got v%b u%b e%0d exp v1 u1 e1", r, sel_vld, sel_unf, sel_eng);
      end
      n_chk++; if (credit !== 9'(mc)) begin n_err++; $display("FAIL unf_credit%0d got %0d exp %0d", r, credit, mc); end
      cmd_vld = '0; cpl_vld = 1; cpl_eng = 2'd1; cpl_dealloc = 0;
      tick(ao, ae, lo, le);
      cpl_vld = 0;
      n_chk++; if (sel_vld !== 1'b0 || sel_unf !== 1'b1) begin
        n_err++; $display("FAIL unf_hold%0d got v%b u%b exp v0 u1", r, sel_vld, sel_unf);
      end
    end
  endtask

  task automatic test_cpl_same();
    logic [N-1:0] ao, ae;
    logic lo, le;
    cmd_vld = 4'b1000; cmd_push = 4'b1000;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== ae) begin n_err++; $display("FAIL same_first got %b exp %b", ao, ae); end
    cpl_vld = 1; cpl_eng = 2'd3; cpl_dealloc = 1;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== 4'b0000) begin n_err++; $display("FAIL same_noack got %b exp 0000", ao); end
    cpl_vld = 0; cpl_dealloc = 0;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== 4'b1000) begin n_err++; $display("FAIL same_next got %b exp 1000", ao); end
    cmd_vld = '0; cpl_vld = 1; cpl_eng = 2'd3;
    tick(ao, ae, lo, le);
    cpl_vld = 0; cmd_vld = '1; cmd_push = '0;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== 4'b0001) begin n_err++; $display("FAIL same_ptr got %b exp 0001", ao); end
    drain(0);
  endtask

  task automatic test_stall();
    logic [N-1:0] ao, ae, exp_first;
    logic lo, le;
    exp_first = 4'b0001 << mp;
    cmd_vld = '1; cmd_push = 4'($urandom); stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick(ao, ae, lo, le);
      n_chk++; if (ao !== 4'b0000 || lo !== 1'b0) begin
        n_err++; $display("FAIL stall_ack%0d got %b/%b exp 0000/0", i, ao, lo);
      end
    end
    stall = 0;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== exp_first) begin n_err++; $display("FAIL stall_release got %b exp %b", ao, exp_first); end
    drain(0);
  endtask

  task automatic test_credit();
    logic [N-1:0] ao, ae;
    logic lo, le;
    int q[$];
    int cyc, b, r;
    cyc = 0;
    cmd_push = '1;
    while (mc != 0 && cyc < 3000) begin
      cmd_vld = ~mbv() & 4'($urandom | $urandom);
      q.delete();
      for (int e = 0; e < N; e++) if (mb[e]) q.push_back(e);
      cpl_vld = 0; cpl_dealloc = 0;
      if (q.size() > 0 && ($urandom_range(0, 3) != 0)) begin
        cpl_vld = 1; cpl_eng = engid_t'(q[$urandom_range(0, q.size() - 1)]);
      end
      tick(ao, ae, lo, le);
      cyc++;
      n_chk++; if (ao !== ae) begin n_err++; $display("FAIL drain_ack got %b exp %b", ao, ae); end
    end
    n_chk++; if (cyc >= 3000) begin n_err++; $display("FAIL drain_timeout credit %0d exp 0", mc); end
    b = mse;
    cmd_vld = '0; cpl_vld = 0;
    for (int e = 0; e < N; e++) begin
      if (mb[e] && e != b) begin
        cpl_vld = 1; cpl_eng = engid_t'(e); cpl_dealloc = 0;
        tick(ao, ae, lo, le);
      end
    end
    cpl_vld = 0;
    n_chk++; if (credit !== 9'd0) begin n_err++; $display("FAIL credit_zero got %0d exp 0", credit); end
    r = (b == 2) ? 3 : 2;
    cmd_vld = 4'b0001 << r; cmd_push = '1;
    for (int i = 0; i < 3; i++) begin
      tick(ao, ae, lo, le);
      n_chk++; if (ao !== 4'b0000) begin n_err++; $display("FAIL nocredit_ack%0d got %b exp 0000", i, ao); end
    end
    cpl_vld = 1; cpl_eng = engid_t'(b); cpl_dealloc = 1;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== 4'b0000) begin n_err++; $display("FAIL dealloc_cycle got %b exp 0000", ao); end
    n_chk++; if (credit !== 9'd1) begin n_err++; $display("FAIL dealloc_credit got %0d exp 1", credit); end
    cpl_vld = 0; cpl_dealloc = 0;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== (4'b0001 << r) || lo !== 1'b1) begin
      n_err++; $display("FAIL credit_regrant got %b/%b exp %b/1", ao, lo, 4'b0001 << r);
    end
    n_chk++; if (credit !== 9'd0) begin n_err++; $display("FAIL credit_regrant_cnt got %0d exp 0", credit); end
    drain(0);
  endtask

  task automatic test_random();
    logic [N-1:0] ao, ae;
    logic lo, le;
    int q[$];
    for (int c = 0; c < 400; c++) begin
      cmd_vld  = 4'($urandom);
      cmd_push = 4'($urandom);
      stall    = ($urandom_range(0, 7) == 0);
      q.delete();
      for (int e = 0; e < N; e++) if (mb[e]) q.push_back(e);
      cpl_vld = 0; cpl_dealloc = 0;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        cpl_vld = 1; cpl_eng = engid_t'(q[$urandom_range(0, q.size() - 1)]);
        cpl_dealloc = (mc < P) && ($urandom_range(0, 3) != 0);
      end
      tick(ao, ae, lo, le);
      n_chk++; if (ao !== ae || lo !== le) begin
        n_err++; $display("FAIL rnd_ack c%0d got %b/%b exp %b/%b", c, ao, lo, ae, le);
      end
      n_chk++; if (sel_vld !== msv || sel_eng !== 2'(mse) || sel_push !== msp || sel_unf !== msu) begin
        n_err++; $display("FAIL rnd_sel c%0d got v%b e%0d p%b u%b exp v%b e%0d p%b u%b",
                          c, sel_vld, sel_eng, sel_push, sel_unf, msv, mse, msp, msu);
      end
      n_chk++; if (busy !== mbv() || credit !== 9'(mc)) begin
        n_err++; $display("FAIL rnd_state c%0d got b%b c%0d exp b%b c%0d", c, busy, credit, mbv(), mc);
      end
    end
    cpl_vld = 0; cpl_dealloc = 0; stall = 0;
    drain(0);
  endtask

  task automatic test_arst();
    logic [N-1:0] ao, ae;
    logic lo, le;
    @(negedge clk); arst = 1; #2; arst = 0;
    model_reset();
    @(posedge clk); #1;
    for (int it = 0; it < 3; it++) begin
      cmd_vld = 4'b0011; cmd_push = 4'b0011;
      tick(ao, ae, lo, le);
      tick(ao, ae, lo, le);
      if (it < 2) begin
        cmd_vld = '0;
        for (int e = 0; e < 2; e++) begin
          cpl_vld = 1; cpl_eng = engid_t'(e); cpl_dealloc = 0;
          tick(ao, ae, lo, le);
        end
        cpl_vld = 0;
      end
    end
    n_chk++; if (credit !== 9'd250 || busy !== 4'b0011) begin
      n_err++; $display("FAIL arst_pre got c%0d b%b exp c250 b0011", credit, busy);
    end
    cmd_vld = '1; cmd_push = '1;
    @(negedge clk); #2; arst = 1; #1;
    n_chk++; if (busy !== 4'b0000 || credit !== 9'd256 || sel_vld !== 1'b0 || ack !== 4'b0000) begin
      n_err++; $display("FAIL arst_async got b%b c%0d v%b a%b exp b0000 c256 v0 a0000", busy, credit, sel_vld, ack);
    end
    cmd_vld = '0; cmd_push = '0;
    @(negedge clk); arst = 0;
    model_reset();
    @(posedge clk); #1;
    cmd_vld = '1; cmd_push = '1;
    tick(ao, ae, lo, le);
    n_chk++; if (ao !== 4'b0001 || ao !== ae) begin n_err++; $display("FAIL arst_first got %b exp 0001", ao); end
    cmd_vld = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_push();
    test_underflow();
    test_cpl_same();
    test_stall();
    test_credit();
    test_random();
    test_arst();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
